serial_out_cmd_ctrl: RTL and testbench



---
 rtl/serial_out_cmd_ctrl_pkg.sv | 39 +++
 rtl/serial_out_cmd_ctrl_if.sv | 30 +++
 rtl/serial_out_cmd_ctrl_gap_timer.sv | 29 ++
 rtl/serial_out_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_out_cmd_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_out_cmd_ctrl_pkg.sv
// Shared definitions for the serial-output command parser: command opcodes,
// control-byte field layout, parser state encoding and power-up periods.
package serial_out_cmd_pkg;

  localparam logic [7:0] CMD_FREQ      = 8'h0A;
  localparam logic [7:0] CMD_DATA      = 8'h0B;
  localparam logic [1:0] CTRL_OP_START = 2'b01;

  // Control byte layout: [7:4] channel, [3] reserved, [2] mode, [1:0] opcode
  localparam int CTRL_CH_MSB   = 7;
  localparam int CTRL_CH_LSB   = 4;
  localparam int CTRL_RSVD_BIT = 3;
  localparam int CTRL_MODE_BIT = 2;
  localparam int CTRL_OP_MSB   = 1;
  localparam int CTRL_OP_LSB   = 0;

  localparam logic [7:0] SLOW_PERIOD_RST = 8'h14;
  localparam logic [7:0] FAST_PERIOD_RST = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    FREQ_PAT,
    SLOW,
    FAST,
    COMMIT_F,
    DATA_PAT,
    CTRL,
    COMMIT_D
  } cmd_state_e;

  // A control byte starts a channel only if reserved is clear, the opcode is
  // START and the channel index exists in this build.
  function automatic logic ctrl_byte_ok(input logic [7:0] b, input int unsigned out_num);
    return (b[CTRL_RSVD_BIT] == 1'b0) &&
           (b[CTRL_OP_MSB:CTRL_OP_LSB] == CTRL_OP_START) &&
           ({28'd0, b[CTRL_CH_MSB:CTRL_CH_LSB]} < out_num);
  endfunction

endpackage

// File: rtl/serial_out_cmd_ctrl_if.sv
// Byte-stream input and configuration outputs of the serial-output command
// parser. The parser connects through the slave modport; whoever feeds bytes
// and consumes the configuration uses the master modport.
interface serial_out_cmd_ctrl_if #(
  parameter int DATA_BIT   = 32,
  parameter int OUTPUT_NUM = 16
);
  logic [7:0]            data_i;
  logic                  rx_done_tick_i;
  logic [DATA_BIT-1:0]   pattern_o;
  logic [7:0]            slow_period_o;
  logic [7:0]            fast_period_o;
  logic                  freq_we_o;
  logic [OUTPUT_NUM-1:0] chan_we_o;
  logic                  mode_o;
  logic                  busy_o;
  logic                  err_tick_o;

  modport slave (
    input  data_i, rx_done_tick_i,
    output pattern_o, slow_period_o, fast_period_o, freq_we_o,
           chan_we_o, mode_o, busy_o, err_tick_o
  );

  modport master (
    output data_i, rx_done_tick_i,
    input  pattern_o, slow_period_o, fast_period_o, freq_we_o,
           chan_we_o, mode_o, busy_o, err_tick_o
  );
endinterface

// File: rtl/serial_out_cmd_ctrl_gap_timer.sv
// Inter-byte gap timer: counts idle clocks while enabled, restarts on every
// clear, and emits a one-cycle expire tick when the gap reaches TIMEOUT_CYC-1.
// A clear in the expiring cycle suppresses the tick.
module cmd_gap_timer #(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Gap counter: held at zero while disabled, restarts on a byte or on expiry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i || !enable_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/serial_out_cmd_ctrl.sv
// UART command parser / sequencer for the diff_freq_serial_out channel bank.
// Frames 0x0A (frequency update) and 0x0B (pattern/channel start) commands
// and issues one-cycle write strobes one clock after the final byte.
// Optional feature: define SERIAL_OUT_CMD_TIMEOUT_EN to abort frames whose
// inter-byte gap reaches TIMEOUT_CYC clocks.
module serial_out_cmd_ctrl
  import serial_out_cmd_pkg::*;
#(
  parameter int PACK_NUM    = 4,
  parameter int DATA_BIT    = 32,
  parameter int OUTPUT_NUM  = 16,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  serial_out_cmd_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(PACK_NUM + 1);

  if (DATA_BIT != PACK_NUM * 8) begin : g_bad_width
    $error("DATA_BIT must equal PACK_NUM*8");
  end
  if (OUTPUT_NUM > 16 || OUTPUT_NUM < 1) begin : g_bad_outnum
    $error("OUTPUT_NUM must be 1..16");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  cmd_state_e            state_q, state_d;
  logic                  tick;
  logic [7:0]            byte_in;
  logic                  idle_like;
  logic                  last_pat;
  logic                  ctrl_ok;
  logic                  expire;
  logic                  err_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_BIT-1:0]   pat_sh;
  logic [7:0]            slow_sh;
  logic [DATA_BIT-1:0]   pattern_q;
  logic [7:0]            slow_q, fast_q;
  logic                  mode_q;
  logic [3:0]            chan_q;
  logic                  err_q;

  assign tick    = bus.rx_done_tick_i;
  assign byte_in = bus.data_i;
  // COMMIT states last one cycle and accept a new command byte like IDLE
  assign idle_like = (state_q == IDLE) || (state_q == COMMIT_F) || (state_q == COMMIT_D);
  assign last_pat  = (cnt_q == CNT_W'(PACK_NUM - 1));
  assign ctrl_ok   = ctrl_byte_ok(byte_in, OUTPUT_NUM);

`ifdef SERIAL_OUT_CMD_TIMEOUT_EN
  cmd_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (tick),
    .enable_i (state_q != IDLE),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Parser state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a frame advances only on byte ticks
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, COMMIT_F, COMMIT_D: begin
        state_d = IDLE;
        if (tick && byte_in == CMD_FREQ)      state_d = FREQ_PAT;
        else if (tick && byte_in == CMD_DATA) state_d = DATA_PAT;
      end
      FREQ_PAT: if (tick && last_pat) state_d = SLOW;
      SLOW:     if (tick)             state_d = FAST;
      FAST:     if (tick)             state_d = COMMIT_F;
      DATA_PAT: if (tick && last_pat) state_d = CTRL;
      CTRL:     if (tick)             state_d = ctrl_ok ? COMMIT_D : IDLE;
      default:                        state_d = IDLE;
    endcase
    if (expire) state_d = IDLE;
  end

  // Discard detection: unknown opcode, rejected control byte or gap timeout
  always_comb begin
    err_d = expire;
    if (tick && idle_like && byte_in != CMD_FREQ && byte_in != CMD_DATA) err_d = 1'b1;
    if (tick && state_q == CTRL && !ctrl_ok)                             err_d = 1'b1;
  end

  // Pattern byte counter, cleared whenever a new command byte is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (idle_like) cnt_q <= '0;
      else if (state_q == FREQ_PAT || state_q == DATA_PAT) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Internal shift/shadow registers; only meaningful once a frame completes
  always_ff @(posedge clk_i) begin
    if (tick && (state_q == FREQ_PAT || state_q == DATA_PAT)) pat_sh <= DATA_BIT'({pat_sh, byte_in});
    if (tick && state_q == SLOW) slow_sh <= byte_in;
  end

  // Visible configuration registers load on the final byte so they change
  // together with the strobe in the COMMIT cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pattern_q <= '0;
      slow_q    <= SLOW_PERIOD_RST;
      fast_q    <= FAST_PERIOD_RST;
      mode_q    <= 1'b0;
      chan_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      if (tick && state_q == FAST && !expire) begin
        slow_q <= slow_sh;
        fast_q <= byte_in;
      end
      if (tick && state_q == CTRL && ctrl_ok) begin
        pattern_q <= pat_sh;
        mode_q    <= byte_in[CTRL_MODE_BIT];
        chan_q    <= byte_in[CTRL_CH_MSB:CTRL_CH_LSB];
      end
    end
  end

  // Strobes and status decoded from the current state
  always_comb begin
    bus.busy_o    = (state_q != IDLE);
    bus.freq_we_o = (state_q == COMMIT_F);
    bus.chan_we_o = '0;
    for (int i = 0; i < OUTPUT_NUM; i++) begin
      bus.chan_we_o[i] = (state_q == COMMIT_D) && (chan_q == 4'(i));
    end
  end

  assign bus.pattern_o     = pattern_q;
  assign bus.slow_period_o = slow_q;
  assign bus.fast_period_o = fast_q;
  assign bus.mode_o        = mode_q;
  assign bus.err_tick_o    = err_q;

endmodule

// File: tb/tb_serial_out_cmd_ctrl.sv
// Self-checking bench for serial_out_cmd_ctrl: directed command frames plus
// randomized traffic, checked every cycle against a frame-level byte model.
module tb_serial_out_cmd_ctrl;
  localparam int PACK_NUM    = 4;
  localparam int DATA_BIT    = 32;
  localparam int OUTPUT_NUM  = 16;
  localparam int TIMEOUT_CYC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_out_cmd_ctrl_if #(.DATA_BIT(DATA_BIT), .OUTPUT_NUM(OUTPUT_NUM)) bus ();

  serial_out_cmd_ctrl #(
    .PACK_NUM    (PACK_NUM),
    .DATA_BIT    (DATA_BIT),
    .OUTPUT_NUM  (OUTPUT_NUM),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: bytes of the currently open frame plus the
  // expected visible outputs for the cycle following the latest edge
  logic [7:0]            frame[$];
  logic [7:0]            m_slow, m_fast;
  logic [DATA_BIT-1:0]   m_pat;
  logic                  m_mode, m_fwe, m_err, m_busy;
  logic [OUTPUT_NUM-1:0] m_cwe;
`ifdef SERIAL_OUT_CMD_TIMEOUT_EN
  int gap = 0;
`endif

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    m_slow = 8'h14; m_fast = 8'h05; m_pat = '0; m_mode = 1'b0;
    m_fwe = 1'b0; m_cwe = '0; m_err = 1'b0; m_busy = 1'b0;
`ifdef SERIAL_OUT_CMD_TIMEOUT_EN
    gap = 0;
`endif
  endtask

  // Apply one clock edge's worth of input to the frame model
  task automatic model_step(input bit t, input logic [7:0] b);
    logic       commit;
    logic [7:0] ctrl;
    commit = 1'b0;
    m_fwe = 1'b0; m_cwe = '0; m_err = 1'b0;
    if (t) begin
`ifdef SERIAL_OUT_CMD_TIMEOUT_EN
      gap = 0;
`endif
      if (frame.size() == 0) begin
        if (b == 8'h0A || b == 8'h0B) frame.push_back(b);
        else m_err = 1'b1;
      end else begin
        frame.push_back(b);
        if (frame[0] == 8'h0A && frame.size() == PACK_NUM + 3) begin
          m_slow = frame[PACK_NUM + 1];
          m_fast = frame[PACK_NUM + 2];
          m_fwe  = 1'b1;
          commit = 1'b1;
          frame.delete();
        end else if (frame[0] == 8'h0B && frame.size() == PACK_NUM + 2) begin
          ctrl = frame[PACK_NUM + 1];
          if (ctrl[3] == 1'b0 && ctrl[1:0] == 2'b01 && int'(ctrl[7:4]) < OUTPUT_NUM) begin
            m_pat = '0;
            for (int i = 0; i < PACK_NUM; i++) m_pat = m_pat * 256 + DATA_BIT'(frame[1 + i]);
            m_mode = ctrl[2];
            m_cwe  = OUTPUT_NUM'(1) << ctrl[7:4];
            commit = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
`ifdef SERIAL_OUT_CMD_TIMEOUT_EN
      gap++;
      if (gap == TIMEOUT_CYC) begin
        m_err = 1'b1;
        frame.delete();
        gap = 0;
      end
`endif
    end
    m_busy = (frame.size() != 0) || commit;
  endtask

  task automatic check_outputs();
    check_val("freq_we",   64'(bus.freq_we_o),     64'(m_fwe));
    check_val("chan_we",   64'(bus.chan_we_o),     64'(m_cwe));
    check_val("err_tick",  64'(bus.err_tick_o),    64'(m_err));
    check_val("busy",      64'(bus.busy_o),        64'(m_busy));
    check_val("slow_per",  64'(bus.slow_period_o), 64'(m_slow));
    check_val("fast_per",  64'(bus.fast_period_o), 64'(m_fast));
    check_val("pattern",   64'(bus.pattern_o),     64'(m_pat));
    check_val("mode",      64'(bus.mode_o),        64'(m_mode));
  endtask

  // One clock: check what the previous edge produced, then drive the next input
  task automatic step(input bit t, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    bus.rx_done_tick_i = t;
    bus.data_i = t ? b : 8'($urandom);
    model_step(t, b);
  endtask

  task automatic send(input logic [7:0] b, input int gap_cyc);
    step(1'b1, b);
    repeat (gap_cyc) step(1'b0, 8'h00);
  endtask

  task automatic send_data_frame(input logic [31:0] pat, input logic [7:0] ctrl, input int g);
    send(8'h0B, g);
    for (int i = 3; i >= 0; i--) send(pat[i*8 +: 8], g);
    send(ctrl, g);
  endtask

  task automatic send_freq_frame(input logic [31:0] pat, input logic [7:0] s,
                                 input logic [7:0] f, input int g);
    send(8'h0A, g);
    for (int i = 3; i >= 0; i--) send(pat[i*8 +: 8], g);
    send(s, g);
    send(f, g);
  endtask

  initial begin
    bus.rx_done_tick_i = 1'b0;
    bus.data_i = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Frequency frame: periods update, pattern untouched
    send_freq_frame(32'h11223344, 8'h20, 8'h06, 0);
    repeat (3) step(1'b0, 8'h00);

    // Every channel with a plain one-shot start
    for (int ch = 0; ch < 16; ch++) begin
      send_data_frame(32'h55555555, {4'(ch), 4'b0001}, 0);
      repeat (2) step(1'b0, 8'h00);
    end

    // Repeat-mode start on channel 3, and the 0x36 byte whose opcode is 2'b10
    send_data_frame(32'hDEADBEEF, 8'h35, 0);
    repeat (2) step(1'b0, 8'h00);
    send_data_frame(32'hCAFEF00D, 8'h36, 0);
    repeat (2) step(1'b0, 8'h00);

    // Reserved bit set in the control byte, then a stray byte in IDLE
    send_data_frame(32'h01020304, 8'h0B, 1);
    repeat (2) step(1'b0, 8'h00);
    send(8'h7F, 2);

    // Back-to-back frames: next command byte lands in the COMMIT cycle
    send_data_frame(32'hA5A5A5A5, 8'h51, 0);
    send_freq_frame(32'h0, 8'h33, 8'h44, 0);
    send_data_frame(32'h12345678, 8'h75, 0);
    send(8'h0B, 0);
    repeat (2) step(1'b0, 8'h00);

    // Long silence mid-frame, then the rest of the frame and a full frame
    send(8'h0B, 0);
    send(8'h55, TIMEOUT_CYC + 5);
    send(8'h55, 0); send(8'h55, 0); send(8'h55, 0); send(8'h21, 2);
    send_data_frame(32'h87654321, 8'h41, 0);
    repeat (3) step(1'b0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind;
      int g;
      kind = $urandom_range(0, 3);
      g = $urandom_range(0, 2);
      case (kind)
        0: send_freq_frame($urandom, 8'($urandom), 8'($urandom), g);
        1: send_data_frame($urandom, {4'($urandom), 1'b0, 1'($urandom), 2'b01}, g);
        2: send_data_frame($urandom, 8'($urandom), g);
        default: send(8'($urandom), g);
      endcase
    end
    repeat (3) step(1'b0, 8'h00);

    // Reset in the middle of a frame after non-default configuration
    send_freq_frame(32'h0, 8'h99, 8'h77, 0);
    send_data_frame(32'hFEEDFACE, 8'h95, 0);
    send(8'h0B, 0); send(8'h55, 0); send(8'h55, 0);
    step(1'b0, 8'h00);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (3) step(1'b0, 8'h00);
    send_data_frame(32'h0BADF00D, 8'hF1, 0);
    repeat (3) step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
